// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: one requester port of the data-memory arbiter
interface dmem_arbiter_if #(parameter int N_Bits = 32) ();
  logic req, we, gnt, rvalid, rerr;
  logic [1:0] storetype;
  logic [N_Bits-1:0] addr, wdata, rdata;
  modport master (output req, we, storetype, addr, wdata, input gnt, rvalid, rdata, rerr);
  modport slave (input req, we, storetype, addr, wdata, output gnt, rvalid, rdata, rerr);
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin data-memory arbiter with bounded port-1 lock
module dmem_arbiter #(
  parameter int N_Bits = 32,
  parameter int MAX_LOCK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  dmem_arbiter_if.slave     m0,
  dmem_arbiter_if.slave     m1,
  input  logic              m1_lock,
  output logic              mem_we,
  output logic [1:0]        mem_storetype,
  output logic [N_Bits-1:0] mem_addr,
  output logic [N_Bits-1:0] mem_wd,
  input  logic [N_Bits-1:0] mem_rd
);
  localparam int CW = $clog2(MAX_LOCK + 1);
  logic last_gnt, lock_q, lock_act, lock_cap, err0, err1, g0, g1;
  logic [CW-1:0] lock_cnt;
  function automatic logic misaligned(input logic [1:0] st, input logic [1:0] a);
    return st == 2'b11 || (st == 2'b01 && a[0]) || (st == 2'b10 && a != 2'b00);
  endfunction
  always_comb begin
    err0 = misaligned(m0.storetype, m0.addr[1:0]);
    err1 = misaligned(m1.storetype, m1.addr[1:0]);
    lock_act = lock_q & m1.req;
    lock_cap = lock_cnt == CW'(MAX_LOCK);
    g0 = rst_n & m0.req & (!m1.req | (lock_act ? lock_cap : last_gnt));
    g1 = rst_n & m1.req & !g0;
    mem_addr = g1 ? m1.addr : m0.addr;
    mem_storetype = g1 ? m1.storetype : m0.storetype;
    mem_wd = g1 ? m1.wdata : m0.wdata;
    mem_we = g0 ? (m0.we & !err0) : g1 ? (m1.we & !err1) : 1'b0;
  end
  assign m0.gnt = g0;
  assign m1.gnt = g1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt <= 1'b1;
      lock_q <= 1'b0;
      lock_cnt <= '0;
      m0.rvalid <= 1'b0;
      m0.rerr <= 1'b0;
      m0.rdata <= '0;
      m1.rvalid <= 1'b0;
      m1.rerr <= 1'b0;
      m1.rdata <= '0;
    end else begin
      if (g0 | g1) last_gnt <= g1;
      lock_q <= g1 & m1_lock;
      lock_cnt <= (g1 & lock_act) ? (lock_cap ? lock_cnt : lock_cnt + CW'(1)) : '0;
      m0.rvalid <= g0;
      m0.rerr <= g0 & err0;
      if (g0) m0.rdata <= (m0.we | err0) ? '0 : mem_rd;
      m1.rvalid <= g1;
      m1.rerr <= g1 & err1;
      if (g1) m1.rdata <= (m1.we | err1) ? '0 : mem_rd;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vectors with a response scoreboard for dmem_arbiter
module tb_dmem_arbiter;
  logic clk = 0, rst_n = 0, m1_lock = 0;
  logic mem_we;
  logic [1:0] mem_storetype;
  logic [31:0] mem_addr, mem_wd, mem_rd;
  logic [31:0] mem [0:15];
  logic [32:0] q0[$], q1[$];
  logic [32:0] e0, e1;
  logic [31:0] last0 = 0, last1 = 0;
  int vecs = 0, errs = 0;
  dmem_arbiter_if #(.N_Bits(32)) m0 ();
  dmem_arbiter_if #(.N_Bits(32)) m1 ();
  dmem_arbiter #(.N_Bits(32), .MAX_LOCK(4)) dut (
    .clk(clk), .rst_n(rst_n), .m0(m0), .m1(m1), .m1_lock(m1_lock),
    .mem_we(mem_we), .mem_storetype(mem_storetype), .mem_addr(mem_addr),
    .mem_wd(mem_wd), .mem_rd(mem_rd)
  );
  always #5 clk = ~clk;
  assign mem_rd = mem[mem_addr[5:2]];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'hA0A0_0000 | i;
    end else if (mem_we) begin
      if (mem_storetype == 2'b00) mem[mem_addr[5:2]][8*mem_addr[1:0] +: 8] <= mem_wd[7:0];
      else if (mem_storetype == 2'b01) mem[mem_addr[5:2]][16*mem_addr[1] +: 16] <= mem_wd[15:0];
      else mem[mem_addr[5:2]] <= mem_wd;
    end
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_rvalid", {m0.rvalid, m1.rvalid, m0.rerr, m1.rerr}, 0);
      chk("rst_rdata", {m0.rdata, m1.rdata}, 0);
      last0 = 0;
      last1 = 0;
    end else begin
      if (m0.rvalid) begin
        if (q0.size() == 0) chk("unexp_rvalid0", 1, 0);
        else begin
          e0 = q0.pop_front();
          chk("resp0", {m0.rerr, m0.rdata}, e0);
        end
        last0 = m0.rdata;
      end else chk("hold0", m0.rdata, last0);
      if (m1.rvalid) begin
        if (q1.size() == 0) chk("unexp_rvalid1", 1, 0);
        else begin
          e1 = q1.pop_front();
          chk("resp1", {m1.rerr, m1.rdata}, e1);
        end
        last1 = m1.rdata;
      end else chk("hold1", m1.rdata, last1);
    end
  end
  task automatic drv0(input logic r, we, input logic [1:0] st, input logic [31:0] a, wd);
    m0.req = r; m0.we = we; m0.storetype = st; m0.addr = a; m0.wdata = wd;
  endtask
  task automatic drv1(input logic r, we, input logic [1:0] st, input logic [31:0] a, wd, input logic lk);
    m1.req = r; m1.we = we; m1.storetype = st; m1.addr = a; m1.wdata = wd; m1_lock = lk;
  endtask
  task automatic step(input logic eg0, eg1, ewe, ee, input logic [31:0] ed);
    #1;
    chk("gnt0", m0.gnt, eg0);
    chk("gnt1", m1.gnt, eg1);
    chk("mem_we", mem_we, ewe);
    if (eg0) q0.push_back({ee, ed});
    if (eg1) q1.push_back({ee, ed});
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("latency0", q0.size(), 0);
    chk("latency1", q1.size(), 0);
  endtask
  initial begin
    drv0(1, 1, 2'b10, 0, 32'h1);
    drv1(1, 1, 2'b10, 4, 32'h2, 0);
    #1;
    chk("rst_gnt", {m0.gnt, m1.gnt}, 0);
    chk("rst_mem_we", mem_we, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    drv0(1, 0, 2'b10, 0, 0);
    drv1(1, 0, 2'b10, 4, 0, 0);
    for (int i = 0; i < 2; i++) begin
      step(1, 0, 0, 0, 32'hA0A0_0000);
      step(0, 1, 0, 0, 32'hA0A0_0001);
    end
    drv0(1, 0, 2'b10, 8, 0);
    drv1(1, 0, 2'b10, 12, 0, 1);
    step(1, 0, 0, 0, 32'hA0A0_0002);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 32'hA0A0_0003);
    step(1, 0, 0, 0, 32'hA0A0_0002);
    step(0, 1, 0, 0, 32'hA0A0_0003);
    drv0(0, 0, 2'b10, 0, 0);
    drv1(0, 0, 2'b10, 4, 0, 1);
    step(0, 0, 0, 0, 0);
    drv0(1, 0, 2'b10, 0, 0);
    drv1(1, 0, 2'b10, 4, 0, 0);
    step(1, 0, 0, 0, 32'hA0A0_0000);
    drv1(0, 0, 2'b10, 4, 0, 0);
    drv0(1, 1, 2'b01, 3, 32'h0000_FFFF);
    step(1, 0, 0, 1, 0);
    drv0(1, 0, 2'b10, 0, 0);
    step(1, 0, 0, 0, 32'hA0A0_0000);
    drv0(1, 1, 2'b00, 5, 32'h0000_00AB);
    step(1, 0, 1, 0, 0);
    drv0(1, 0, 2'b10, 4, 0);
    step(1, 0, 0, 0, 32'hA0A0_AB01);
    drv0(0, 0, 2'b10, 0, 0);
    drv1(1, 0, 2'b10, 2, 0, 0);
    step(0, 1, 0, 1, 0);
    drv1(1, 1, 2'b11, 0, 32'hDEAD_BEEF, 0);
    step(0, 1, 0, 1, 0);
    drv1(1, 0, 2'b01, 2, 0, 0);
    step(0, 1, 0, 0, 32'hA0A0_0000);
    drv1(1, 1, 2'b10, 8, 32'h1234_5678, 0);
    step(0, 1, 1, 0, 0);
    drv1(0, 0, 2'b10, 0, 0, 0);
    drv0(1, 0, 2'b10, 8, 0);
    step(1, 0, 0, 0, 32'h1234_5678);
    drv0(1, 0, 2'b10, 12, 0);
    #1;
    chk("pre_rst_gnt0", m0.gnt, 1);
    rst_n = 0;
    #1;
    chk("in_rst_gnt0", m0.gnt, 0);
    chk("async_rdata", {m0.rdata, m1.rdata}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    drv0(0, 0, 2'b10, 0, 0);
    rst_n = 1;
    drv1(1, 0, 2'b10, 8, 0, 0);
    step(0, 1, 0, 0, 32'hA0A0_0002);
    drv1(0, 0, 2'b10, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("q_empty", {q0.size(), q1.size()}, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter N_Bits, default 32: address/data width.
REQ-002 Parameter MAX_LOCK, default 4: max consecutive locked grants to port 1 while port 0 waits.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 m0_req  in  1  port 0 (CPU load/store) access request.
REQ-006 m0_we  in  1  port 0 write (1) / read (0).
REQ-007 m0_storetype  in  2  port 0 size: 00 byte, 01 half, 10 word, 11 illegal.
REQ-008 m0_addr  in  N_Bits  port 0 byte address.
REQ-009 m0_wdata  in  N_Bits  port 0 write data.
REQ-010 m0_gnt  out  1  port 0 request accepted this cycle (combinational).
REQ-011 m0_rvalid  out  1  port 0 response valid, one-cycle pulse.
REQ-012 m0_rdata  out  N_Bits  port 0 read data, registered.
REQ-013 m0_rerr  out  1  port 0 misaligned/illegal access flag, valid with m0_rvalid.
REQ-014 m1_req, m1_we, m1_storetype, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata, m1_rerr: same as port 0, for port 1 (refill/DMA).
REQ-015 m1_lock  in  1  port 1 requests retention of grant for the next cycle.
REQ-016 mem_we  out  1  memory write enable (combinational).
REQ-017 mem_storetype  out  2  memory access size (combinational).
REQ-018 mem_addr  out  N_Bits  memory address (combinational).
REQ-019 mem_wd  out  N_Bits  memory write data (combinational).
REQ-020 mem_rd  in  N_Bits  memory combinational read data.

Function
REQ-021 At most one of m0_gnt/m1_gnt SHALL be high per cycle; gnt only when the port's req is high.
REQ-022 One request only: that port SHALL be granted same cycle.
REQ-023 Both request, no active lock: port not granted most recently SHALL win (round-robin via last_gnt flop).
REQ-024 Lock active (previous grant to port 1 with m1_lock=1, m1_req=1 now): port 1 SHALL win unless lock_cnt==MAX_LOCK and m0_req=1, then port 0 wins.
REQ-025 lock_cnt SHALL increment per consecutive locked port-1 grant, saturate at MAX_LOCK, clear on any port-0 grant or any cycle with no port-1 grant.
REQ-026 mem_addr/mem_storetype/mem_wd SHALL mux from granted port; from port 0 when no grant.
REQ-027 Misaligned: storetype 01 with addr[0]=1, storetype 10 with addr[1:0]!=00, or storetype 11 -> access is an error.
REQ-028 mem_we SHALL equal granted port's we AND not error; 0 when no grant.
REQ-029 Every grant SHALL produce exactly one rvalid pulse on that port next cycle; rerr = error flag of that access.
REQ-030 Read without error: rdata SHALL be mem_rd sampled at grant edge; writes or errors: rdata = 0.
REQ-031 rdata SHALL hold its value until the next response on that port.
REQ-032 Back-to-back grants SHALL be supported every cycle (throughput 1 access/cycle, latency 1).
REQ-033 m1_lock with m1_req=0 SHALL be ignored and lock released.

Reset
REQ-034 On rst_n low, immediately: m0/m1_rvalid=0, m0/m1_rerr=0, m0/m1_rdata=0, lock_cnt=0, lock inactive, last_gnt=port 1 (port 0 wins first tie).
REQ-035 During reset gnt and mem_we SHALL be 0; reset asserted mid-access SHALL drop pending response without pulse.
REQ-036 First rising edge after rst_n rises SHALL arbitrate normally.

Verification
REQ-037 Both req word reads every cycle, no lock -> grants alternate 0,1,0,1; each rvalid one cycle after its grant with correct rdata.
REQ-038 m1_req=m1_lock=1 continuous, m0_req=1, MAX_LOCK=4 -> grant sequence 1 (tie loss for 0 on first cycle? no: 0 first), then 1,1,1,1,1(count reaches 4) then 0, then 1.
REQ-039 m0 store half to addr 0x3 -> mem_we=0, m0_rvalid=1 with m0_rerr=1 next cycle; memory unchanged on readback at 0x0.
REQ-040 m0 store byte 0xAB at 0x5, then read word at 0x4 -> m0_rdata[15:8]=0xAB, rerr=0.
REQ-041 rst_n low on cycle after grant -> rvalid stays 0, rdata=0; after release, single m1 read granted with latency 1.
